uniform_rng_gen: RTL and testbench
==================================

UNIFORM_RNG_GEN -- requirements
Module: uniform_rng_gen

Interface
- REQ-001 Parameter WIDTH, 16: sample width per channel, in bits; legal range 4..32.
- REQ-002 Parameter CHANNELS, 4: number of independent generator channels; legal range 1..16.
- REQ-003 Parameter NOISE_SHIFT, 8: arithmetic right shift applied to noise in dither mode; legal range 0..WIDTH-1.
- REQ-004 clk  in  1  single clock; all logic on its rising edge.
- REQ-005 rst_n  in  1  reset, synchronous, active-low.
- REQ-006 seed_load  in  1  single-cycle pulse that loads new seeds.
- REQ-007 seed_data  in  32  base seed, sampled when seed_load=1.
- REQ-008 cfg_mode  in  2  0=raw, 1=range, 2=dither, 3=reserved (treated as raw).
- REQ-009 cfg_lo, cfg_hi  in  WIDTH each  signed inclusive bounds for range mode.
- REQ-010 in_valid / in_ready  in / out  1 / 1  input handshake.
- REQ-011 in_data  in  CHANNELS*WIDTH  signed samples for dither mode; channel k at bits [k*WIDTH +: WIDTH].
- REQ-012 out_valid / out_ready  out / in  1 / 1  output handshake.
- REQ-013 out_data  out  CHANNELS*WIDTH  result per channel, same packing as in_data.

Function
- REQ-014 Each channel SHALL hold a 32-bit Galois LFSR: next = (s<<1) ^ (s[31] ? 0x0040_0007 : 0).
- REQ-015 A transfer SHALL be accepted when in_valid=1 and in_ready=1; each accept SHALL advance every LFSR exactly once, and no LFSR SHALL advance otherwise.
- REQ-016 Per-channel random value r SHALL be the low WIDTH bits of the advanced state.
- REQ-017 Pipeline SHALL have 2 register stages; out_valid SHALL rise 2 cycles after an accept when out_ready=1; throughput SHALL be 1 transfer per cycle.
- REQ-018 in_ready SHALL equal (stage2 empty OR out_ready) AND NOT seed_load.
- REQ-019 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
- REQ-020 cfg_mode, cfg_lo, cfg_hi and in_data SHALL be captured at accept; changes after accept SHALL NOT affect in-flight results.
- REQ-021 Raw mode: out = r.
- REQ-022 Range mode: span = cfg_hi - cfg_lo + 1 as a (WIDTH+1)-bit unsigned value; out = cfg_lo + ((r * span) >> WIDTH), held to WIDTH bits.
- REQ-023 Range mode with cfg_hi < cfg_lo (signed compare) SHALL output cfg_lo.
- REQ-024 Dither mode: out = saturate(in_data_k + (signed r >>> NOISE_SHIFT)) to signed WIDTH limits.
- REQ-025 When seed_load=1, channel k SHALL load seed_data ^ (k * 0x9E37_79B9 mod 2^32); a computed zero SHALL be replaced by 0x0000_0001.
- REQ-026 seed_load SHALL flush both stages; out_valid SHALL be 0 on the next cycle; no transfer SHALL be accepted that cycle.
- REQ-027 seed_load SHALL take priority over a simultaneous in_valid.

Reset
- REQ-028 With rst_n=0 at a clock edge, channel k SHALL load 0x0000_0002 ^ (k * 0x9E37_79B9) under the same zero rule.
- REQ-029 During reset, out_valid=0, out_data=0 and in_ready=0; in-flight data SHALL be discarded.
- REQ-030 in_ready SHALL be 1 in the first cycle after rst_n returns to 1.

Structure
- REQ-031 Package uniform_rng_pkg SHALL hold LFSR_POLY, DEFAULT_SEED, SEED_SPREAD (0x9E37_79B9) and the mode enum.
- REQ-032 Sub-module lfsr32_galois (inputs: load, load_value, advance; output: state) SHALL be instantiated once per channel.

Verification
- REQ-033 Reset; raw mode; WIDTH=16; out_ready=1; three accepts -> ch0 out = 0x0004, 0x0008, 0x0010, first result 2 cycles after the first accept.
- REQ-034 Range mode, lo=-2, hi=2; first accept -> ch0 out = 0xFFFE (-2). Over 10000 accepts, each of -2..2 SHALL occur 2000±200 times and no value outside the range SHALL occur.
- REQ-035 Dither mode, NOISE_SHIFT=8, in=0x7FF0, r=0x7FFF -> out = 0x7FFF (saturated). Same case with in=0x8005, r=0x8000 -> out = 0x8000.
- REQ-036 out_ready=0 for 5 cycles with in_valid=1 -> out_data stable, in_ready=0 after the pipe fills, LFSR states unchanged. On release, no sample is lost or duplicated.
- REQ-037 seed_load with seed_data=0 in the middle of a stream -> next cycle out_valid=0 and ch0 state = 0x0000_0001. The next accept gives ch0 raw = 0x0002.
- REQ-038 Range mode with lo=5, hi=3 -> out = 0x0005 on every accept.

Source files
------------

// File: rtl/uniform_rng_gen_pkg.sv
// uniform_rng_pkg: shared constants, mode enum and LFSR/seed helpers
// for the uniform_rng_gen slice.
package uniform_rng_pkg;

  localparam logic [31:0] LFSR_POLY    = 32'h0040_0007;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0002;
  localparam logic [31:0] SEED_SPREAD  = 32'h9E37_79B9;

  typedef enum logic [1:0] {
    MODE_RAW    = 2'd0,
    MODE_RANGE  = 2'd1,
    MODE_DITHER = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  function automatic logic [31:0] lfsr_next(
    input logic [31:0] s
  );
    return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
  endfunction

  // An all-zero state would lock the LFSR, so it becomes 1.
  function automatic logic [31:0] chan_seed(
    input logic [31:0] base,
    input logic [31:0] k
  );
    logic [31:0] v;
    v = base ^ (SEED_SPREAD * k);
    if (v == 32'h0) v = 32'h1;
    return v;
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// lfsr32_galois: one 32-bit Galois LFSR channel.
// Ports: clk; load/load_value (wins over advance); advance; state.
module lfsr32_galois
  import uniform_rng_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        advance,
  output logic [31:0] state
);

  always_ff @(posedge clk) begin
    if (load)
      state <= load_value;
    else if (advance)
      state <= lfsr_next(state);
  end

endmodule

// File: rtl/uniform_rng_gen.sv
// uniform_rng_gen: multi-channel LFSR generator, raw/range/dither,
// 2-stage valid/ready pipe. Ports: clk, rst_n, seed_*, cfg_*, in_*, out_*.
module uniform_rng_gen
  import uniform_rng_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 4,
  parameter int NOISE_SHIFT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      seed_load,
  input  logic [31:0]               seed_data,
  input  logic [1:0]                cfg_mode,
  input  logic [WIDTH-1:0]          cfg_lo,
  input  logic [WIDTH-1:0]          cfg_hi,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data
);

  localparam int CW = CHANNELS * WIDTH;

  logic          adv;
  logic          accept;
  logic          lfsr_load;
  logic [CW-1:0] r_now;
  logic [CW-1:0] res;

  logic             v1;
  mode_e            m1;
  logic [WIDTH-1:0] lo1;
  logic [WIDTH-1:0] hi1;
  logic [CW-1:0]    d1;
  logic [CW-1:0]    r1;

  // Whole pipe moves together; it only freezes on output back-pressure.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = rst_n && adv && !seed_load;
  assign accept    = in_valid && in_ready;
  assign lfsr_load = !rst_n || seed_load;

  function automatic logic [WIDTH-1:0] calc(
    input mode_e            m,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] hi,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] r
  );
    logic [WIDTH:0]          span;
    logic [2*WIDTH:0]        prod;
    logic [WIDTH-1:0]        off;
    logic signed [WIDTH-1:0] noise;
    logic signed [WIDTH:0]   sum;
    logic [WIDTH-1:0]        o;
    span  = {hi[WIDTH-1], hi} - {lo[WIDTH-1], lo}
          + (WIDTH+1)'(1);
    prod  = (2*WIDTH+1)'(r) * (2*WIDTH+1)'(span);
    off   = WIDTH'(prod >> WIDTH);
    noise = $signed(r) >>> NOISE_SHIFT;
    sum   = $signed({d[WIDTH-1], d})
          + $signed({noise[WIDTH-1], noise});
    o     = r;
    unique case (1'b1)
      m == MODE_RANGE: begin
        if ($signed(hi) < $signed(lo)) o = lo;
        else o = lo + off;
      end
      m == MODE_DITHER: begin
        // Top two sum bits disagree -> overflowed WIDTH.
        if (sum[WIDTH] != sum[WIDTH-1])
          o = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                         : {1'b0, {(WIDTH-1){1'b1}}};
        else
          o = sum[WIDTH-1:0];
      end
      default: o = r;
    endcase
    return o;
  endfunction

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [31:0] state;
    logic [31:0] seed;

    assign seed = chan_seed(rst_n ? seed_data : DEFAULT_SEED, 32'(k));

    lfsr32_galois u_lfsr (
      .clk        (clk),
      .load       (lfsr_load),
      .load_value (seed),
      .advance    (accept),
      .state      (state)
    );

    // r comes from the state the LFSR is about to take.
    assign r_now[k*WIDTH +: WIDTH] = WIDTH'(lfsr_next(state));
    assign res[k*WIDTH +: WIDTH] =
      calc(m1, lo1, hi1, d1[k*WIDTH +: WIDTH], r1[k*WIDTH +: WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      m1        <= MODE_RAW;
      lo1       <= '0;
      hi1       <= '0;
      d1        <= '0;
      r1        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (seed_load) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      v1        <= accept;
      out_valid <= v1;
      if (accept) begin
        m1  <= mode_e'(cfg_mode);
        lo1 <= cfg_lo;
        hi1 <= cfg_hi;
        d1  <= in_data;
        r1  <= r_now;
      end
      if (v1) out_data <= res;
    end
  end

endmodule

// File: tb/tb_uniform_rng_gen.sv
// tb_uniform_rng_gen: randomized scenarios checked against a
// behavioural model of the generator kept in the bench.
module tb_uniform_rng_gen;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int NS = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          seed_load;
  logic [31:0]   seed_data;
  logic [1:0]    cfg_mode;
  logic [W-1:0]  cfg_lo, cfg_hi;
  logic          in_valid, in_ready;
  logic [CH*W-1:0] in_data, out_data;
  logic          out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  logic [CH*W-1:0] exp_q[$];
  logic [CH*W-1:0] got_q[$];
  logic [CH*W-1:0] mon_e;
  logic [31:0]     ms[CH];
  logic [31:0]     dst[CH];

  always #5 clk = ~clk;

  uniform_rng_gen #(.WIDTH(W), .CHANNELS(CH), .NOISE_SHIFT(NS)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load),
    .seed_data(seed_data), .cfg_mode(cfg_mode),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  for (genvar g = 0; g < CH; g++) begin : g_tap
    assign dst[g] = dut.g_ch[g].state;
  end

  // ---- reference model ----
  function automatic logic [31:0] m_step(logic [31:0] s);
    logic [32:0] t;
    t = {s, 1'b0};
    if (t[32]) t[31:0] = t[31:0] ^ 32'h0040_0007;
    return t[31:0];
  endfunction

  function automatic logic [31:0] m_seed(logic [31:0] b, int k);
    longint p;
    logic [31:0] v;
    p = longint'(k) * 64'h9E37_79B9;
    v = b ^ p[31:0];
    if (v == 0) v = 32'h1;
    return v;
  endfunction

  function automatic logic [W-1:0] m_chan(int mode,
      logic [W-1:0] lo, logic [W-1:0] hi,
      logic [W-1:0] d, logic [W-1:0] r);
    int lo_i, hi_i, d_i, r_s, n, s;
    longint span, q, v;
    lo_i = $signed(lo);
    hi_i = $signed(hi);
    d_i  = $signed(d);
    r_s  = $signed(r);
    if (mode == 1) begin
      if (hi_i < lo_i) return lo;
      span = hi_i - lo_i + 1;
      q = (longint'(r) * span) / (longint'(1) << W);
      v = lo_i + q;
      return W'(v);
    end else if (mode == 2) begin
      n = r_s >>> NS;
      s = d_i + n;
      if (s > (1 << (W-1)) - 1) s = (1 << (W-1)) - 1;
      if (s < -(1 << (W-1))) s = -(1 << (W-1));
      return W'(s);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (!rst_n || seed_load) begin
      while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
      for (int k = 0; k < CH; k++)
        ms[k] = m_seed(!rst_n ? 32'h2 : seed_data, k);
    end else if (in_valid && in_ready) begin
      for (int k = 0; k < CH; k++) begin
        ms[k] = m_step(ms[k]);
        mon_e[k*W +: W] = m_chan(int'(cfg_mode), cfg_lo, cfg_hi,
                                 in_data[k*W +: W], ms[k][W-1:0]);
      end
      exp_q.push_back(mon_e);
    end
  end

  // ---- stimulus helpers ----
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; seed_load = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic drain();
    in_valid = 1'b0; seed_load = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic rnd_data();
    for (int k = 0; k < CH; k++) in_data[k*W +: W] = W'($urandom);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      errors++; $display("FAIL reset_out_data got %h want 0", out_data);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    for (int k = 0; k < CH; k++) begin
      checks++;
      if (dst[k] !== m_seed(32'h2, k)) begin
        errors++;
        $display("FAIL reset_seed ch%0d got %h want %h",
                 k, dst[k], m_seed(32'h2, k));
      end
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    got_q.delete(); exp_q.delete();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_raw();
    cfg_mode = 2'd0; out_ready = 1'b1; rnd_data();
    in_valid = 1'b1;
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL raw_lat1 got %b want 0", out_valid);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_data[W-1:0] !== 16'h0004) begin
      errors++;
      $display("FAIL raw_lat2 got v=%b d=%h want v=1 d=0004",
               out_valid, out_data[W-1:0]);
    end
    cyc();
    drain();
    checks++;
    if (got_q.size() != 3) begin
      errors++; $display("FAIL raw_count got %0d want 3", got_q.size());
    end else begin
      checks++;
      if (got_q[0][W-1:0] !== 16'h0004 || got_q[1][W-1:0] !== 16'h0008 ||
          got_q[2][W-1:0] !== 16'h0010) begin
        errors++;
        $display("FAIL raw_seq got %h %h %h want 0004 0008 0010",
                 got_q[0][W-1:0], got_q[1][W-1:0], got_q[2][W-1:0]);
      end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL raw_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_range();
    int hist[5];
    int outl;
    int v;
    do_reset();
    cfg_mode = 2'd1; cfg_lo = -16'sd2; cfg_hi = 16'sd2;
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (10000) begin rnd_data(); cyc(); end
    drain();
    checks++;
    if (got_q.size() != 10000) begin
      errors++; $display("FAIL range_count got %0d want 10000", got_q.size());
    end
    checks++;
    if (got_q.size() == 0 || got_q[0][W-1:0] !== 16'hFFFE) begin
      errors++;
      $display("FAIL range_first got %h want fffe",
               got_q.size() ? got_q[0][W-1:0] : 16'hx);
    end
    for (int i = 0; i < 5; i++) hist[i] = 0;
    outl = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      v = $signed(got_q[i][W-1:0]);
      if (v < -2 || v > 2) outl++;
      else hist[v+2]++;
    end
    checks++;
    if (outl != 0) begin
      errors++; $display("FAIL range_outside got %0d want 0", outl);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (hist[i] < 1800 || hist[i] > 2200) begin
        errors++;
        $display("FAIL range_hist[%0d] got %0d want 2000+-200", i-2, hist[i]);
      end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL range_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_range_inverted();
    cfg_mode = 2'd1; cfg_lo = 16'd5; cfg_hi = 16'd3;
    in_valid = 1'b1;
    repeat (20) begin
      rnd_data(); out_ready = ($urandom_range(0, 3) != 0); cyc();
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL inv_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      for (int k = 0; k < CH; k++) begin
        checks++;
        if (got_q[i][k*W +: W] !== 16'h0005) begin
          errors++;
          $display("FAIL inv_val[%0d] ch%0d got %h want 0005",
                   i, k, got_q[i][k*W +: W]);
        end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_dither();
    logic [31:0] seeds[2];
    logic [W-1:0] ins[2];
    logic [W-1:0] outs[2];
    seeds[0] = 32'h8000_3FFC; ins[0] = 16'h7FF0; outs[0] = 16'h7FFF;
    seeds[1] = 32'h0000_4000; ins[1] = 16'h8005; outs[1] = 16'h8000;
    cfg_mode = 2'd2;
    for (int c = 0; c < 2; c++) begin
      seed_load = 1'b1; seed_data = seeds[c];
      cyc();
      seed_load = 1'b0;
      rnd_data(); in_data[W-1:0] = ins[c];
      in_valid = 1'b1;
      cyc();
      drain();
      checks++;
      if (got_q.size() != 1 || got_q[0][W-1:0] !== outs[c]) begin
        errors++;
        $display("FAIL dither_sat%0d got n=%0d d=%h want n=1 d=%h", c,
                 got_q.size(), got_q.size() ? got_q[0][W-1:0] : 16'hx,
                 outs[c]);
      end
      checks++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
        errors++; $display("FAIL dither_model%0d mismatch vs model", c);
      end
      got_q.delete(); exp_q.delete();
    end
    repeat (300) begin
      rnd_data();
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL dither_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL dither_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall();
    logic [CH*W-1:0] hold;
    cfg_mode = 2'd0; out_ready = 1'b1; in_valid = 1'b1;
    repeat (4) begin rnd_data(); cyc(); end
    out_ready = 1'b0;
    #1;
    hold = exp_q[got_q.size()];
    repeat (5) begin
      rnd_data();
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_data !== hold) begin
        errors++;
        $display("FAIL stall_hold got v=%b d=%h want v=1 d=%h",
                 out_valid, out_data, hold);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ready got %b want 0", in_ready);
      end
      for (int k = 0; k < CH; k++) begin
        checks++;
        if (dst[k] !== ms[k]) begin
          errors++;
          $display("FAIL stall_state ch%0d got %h want %h", k, dst[k], ms[k]);
        end
      end
    end
    out_ready = 1'b1;
    repeat (3) begin rnd_data(); cyc(); end
    drain();
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() != 7) begin
      errors++;
      $display("FAIL stall_count got %0d want 7", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_seed_flush();
    cfg_mode = 2'd0; out_ready = 1'b1; in_valid = 1'b1;
    repeat (6) begin rnd_data(); cyc(); end
    seed_load = 1'b1; seed_data = 32'h0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL seed_ready got %b want 0", in_ready);
    end
    cyc();
    seed_load = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL seed_flush got %b want 0", out_valid);
    end
    checks++;
    if (dst[0] !== 32'h1) begin
      errors++; $display("FAIL seed_ch0 got %h want 00000001", dst[0]);
    end
    for (int k = 1; k < CH; k++) begin
      checks++;
      if (dst[k] !== m_seed(32'h0, k)) begin
        errors++;
        $display("FAIL seed_ch%0d got %h want %h", k, dst[k], m_seed(32'h0, k));
      end
    end
    cyc();
    drain();
    checks++;
    if (got_q.size() == 0 || got_q[got_q.size()-1][W-1:0] !== 16'h0002) begin
      errors++; $display("FAIL seed_next_raw got other want 0002");
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL seed_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL seed_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    repeat (3000) begin
      rnd_data();
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_lo    = W'($urandom);
      cfg_hi    = W'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      seed_load = ($urandom_range(0, 39) == 0);
      seed_data = $urandom;
      cyc();
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; seed_load = 1'b0; seed_data = '0;
    cfg_mode = '0; cfg_lo = '0; cfg_hi = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_raw();
    test_range();
    test_range_inverted();
    test_dither();
    test_stall();
    test_seed_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
